// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, issues one memory request at a time
// and presents the returned instruction with its PC and PC+4 until it is consumed.
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   PCSrc_i,
  input  logic [ADDR_WIDTH-1:0]  PCTarget_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [ADDR_WIDTH-1:0]  flush_pc_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic                   instr_valid_o,
  output logic [ADDR_WIDTH-1:0]  PC_o,
  output logic [ADDR_WIDTH-1:0]  PCPlus4_o
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_VALID = 2'd3
  } state_t;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'(32'h0000_0013);
  localparam logic [ADDR_WIDTH-1:0]  PC_STEP   = ADDR_WIDTH'(4);

  // Instructions are word aligned; the low two address bits are never fetched.
  function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:2], 2'b00};
  endfunction

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  pc_plus4;
  logic [ADDR_WIDTH-1:0]  next_seq_pc;

  assign pc_plus4    = pc_q + PC_STEP;
  assign next_seq_pc = PCSrc_i ? PCTarget_i : pc_plus4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;

    if (flush_i) begin
      // A flush leaves DRAIN behind whenever memory still owes us a response.
      pc_d = align_pc(flush_pc_i);
      unique case (state_q)
        S_REQ:   state_d = S_DRAIN;
        S_WAIT:  state_d = imem_rvalid_i ? S_REQ : S_DRAIN;
        S_DRAIN: state_d = imem_rvalid_i ? S_REQ : S_DRAIN;
        S_VALID: state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            instr_d = imem_rdata_i;
            state_d = S_VALID;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid_i) begin
            state_d = S_REQ;
          end
        end
        S_VALID: begin
          if (!stall_i) begin
            pc_d    = align_pc(next_seq_pc);
            state_d = S_REQ;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Reset sits in REQ, so the strobe must be gated while reset is held.
  assign imem_req_o    = (state_q == S_REQ) && !rst_i;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = (state_q == S_VALID);
  assign PC_o          = pc_q;
  assign PCPlus4_o     = pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-programmable memory responder and a
// scoreboard of expected (PC, instruction) pairs checked when instr_valid_o rises.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        PCSrc_i;
  logic [31:0] PCTarget_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i  = '0;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic [31:0] PC_o;
  logic [31:0] PCPlus4_o;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_WIDTH (32),
    .INSTR_WIDTH(32),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .PCSrc_i      (PCSrc_i),
    .PCTarget_i   (PCTarget_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_o      (instr_o),
    .instr_valid_o(instr_valid_o),
    .PC_o         (PC_o),
    .PCPlus4_o    (PCPlus4_o)
  );

  int errors = 0;
  int checks = 0;
  int mem_lat = 1;
  int overlap_cnt = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[23:0] ^ 24'hA5A5A5, 8'h13};
  endfunction

  // Memory responder: sample the request on the falling edge, answer mem_lat cycles later.
  logic        req_s;
  logic [31:0] addr_s, addr_p;
  bit          pend = 1'b0;
  int          cnt = 0;
  always begin
    @(negedge clk);
    req_s  = imem_req_o;
    addr_s = imem_addr_o;
    @(posedge clk);
    #1;
    imem_rvalid_i = 1'b0;
    if (rst_i) begin
      pend  = 1'b0;
      req_s = 1'b0;
    end
    if (req_s) begin
      if (pend) overlap_cnt++;
      pend   = 1'b1;
      cnt    = mem_lat;
      addr_p = addr_s;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(addr_p);
        pend          = 1'b0;
      end
    end
  end

  task automatic wait_valid(input int max, output int n, output bit to);
    n  = 0;
    to = 1'b1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (instr_valid_o === 1'b1) begin
        n  = i;
        to = 1'b0;
        return;
      end
    end
  endtask

  task automatic consume(input bit src, input logic [31:0] tgt);
    PCSrc_i    = src;
    PCTarget_i = tgt;
    stall_i    = 1'b0;
    @(posedge clk);
    #1;
    stall_i    = 1'b1;
    PCSrc_i    = 1'b0;
    PCTarget_i = '0;
  endtask

  task automatic test_reset;
    int n; bit to; exp_t e;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid_o); end
    checks++; if (instr_o !== NOP) begin errors++; $display("FAIL rst_instr: got %h want %h", instr_o, NOP); end
    checks++; if (PC_o !== RST_PC) begin errors++; $display("FAIL rst_pc: got %h want %h", PC_o, RST_PC); end
    rst_i = 1'b0;
    sb.push_back('{RST_PC, 32'h0050_0093});
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC) begin errors++; $display("FAIL first_req: got req=%b addr=%h want 1 %h", imem_req_o, imem_addr_o, RST_PC); end
    wait_valid(10, n, to);
    checks++; if (to || n !== 2) begin errors++; $display("FAIL first_latency: got cycle %0d (timeout=%0d) want 2", n, to); end
    e = sb.pop_front();
    checks++; if (instr_o !== e.instr) begin errors++; $display("FAIL first_instr: got %h want %h", instr_o, e.instr); end
    checks++; if (PC_o !== e.pc) begin errors++; $display("FAIL first_pc: got %h want %h", PC_o, e.pc); end
    checks++; if (PCPlus4_o !== e.pc + 32'd4) begin errors++; $display("FAIL first_pc4: got %h want %h", PCPlus4_o, e.pc + 32'd4); end
  endtask

  task automatic test_stall;
    int n; bit to; exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h0050_0093 || PC_o !== RST_PC) begin
        errors++; $display("FAIL stall_hold: got v=%b instr=%h pc=%h want 1 00500093 %h", instr_valid_o, instr_o, PC_o, RST_PC);
      end
    end
    consume(1'b0, 32'h0);
    @(negedge clk);
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL stall_drop_valid: got %b want 0", instr_valid_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h104) begin errors++; $display("FAIL seq_req: got req=%b addr=%h want 1 00000104", imem_req_o, imem_addr_o); end
    sb.push_back('{32'h104, mem_word(32'h104)});
    wait_valid(10, n, to);
    checks++; if (to || n !== 2) begin errors++; $display("FAIL seq_latency: got %0d (timeout=%0d) want 2", n, to); end
    e = sb.pop_front();
    checks++; if (instr_o !== e.instr || PC_o !== e.pc || PCPlus4_o !== e.pc + 32'd4) begin
      errors++; $display("FAIL seq_data: got %h %h %h want %h %h %h", instr_o, PC_o, PCPlus4_o, e.instr, e.pc, e.pc + 32'd4);
    end
  endtask

  task automatic test_branch;
    int n; bit to; exp_t e;
    consume(1'b1, 32'h2002);
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h2000) begin errors++; $display("FAIL branch_req: got req=%b addr=%h want 1 00002000", imem_req_o, imem_addr_o); end
    sb.push_back('{32'h2000, mem_word(32'h2000)});
    wait_valid(10, n, to);
    e = sb.pop_front();
    checks++; if (to || instr_o !== e.instr || PC_o !== e.pc) begin errors++; $display("FAIL branch_data: got %h %h want %h %h", instr_o, PC_o, e.instr, e.pc); end
    consume(1'b0, 32'h2002);
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h2004) begin errors++; $display("FAIL notaken_req: got req=%b addr=%h want 1 00002004", imem_req_o, imem_addr_o); end
    sb.push_back('{32'h2004, mem_word(32'h2004)});
    wait_valid(10, n, to);
    e = sb.pop_front();
    checks++; if (to || instr_o !== e.instr || PC_o !== e.pc) begin errors++; $display("FAIL notaken_data: got %h %h want %h %h", instr_o, PC_o, e.instr, e.pc); end
  endtask

  task automatic test_flush_wait;
    int n; bit to; exp_t e;
    mem_lat = 3;
    consume(1'b0, 32'h0);
    @(posedge clk);
    #1;
    flush_i    = 1'b1;
    flush_pc_i = 32'h80;
    stall_i    = 1'b0;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    stall_i = 1'b1;
    @(negedge clk);
    checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin errors++; $display("FAIL fw_drain: got v=%b req=%b want 0 0", instr_valid_o, imem_req_o); end
    checks++; if (PC_o !== 32'h80) begin errors++; $display("FAIL fw_pc: got %h want 00000080", PC_o); end
    @(negedge clk);
    checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin errors++; $display("FAIL fw_stale: got v=%b req=%b want 0 0", instr_valid_o, imem_req_o); end
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h80) begin errors++; $display("FAIL fw_req: got req=%b addr=%h want 1 00000080", imem_req_o, imem_addr_o); end
    checks++; if (instr_valid_o !== 1'b0 || instr_o !== mem_word(32'h2004)) begin errors++; $display("FAIL fw_instr_kept: got v=%b instr=%h want 0 %h", instr_valid_o, instr_o, mem_word(32'h2004)); end
    sb.push_back('{32'h80, mem_word(32'h80)});
    wait_valid(12, n, to);
    checks++; if (to || n !== 4) begin errors++; $display("FAIL fw_latency: got %0d (timeout=%0d) want 4", n, to); end
    e = sb.pop_front();
    checks++; if (instr_o !== e.instr || PC_o !== e.pc) begin errors++; $display("FAIL fw_data: got %h %h want %h %h", instr_o, PC_o, e.instr, e.pc); end
  endtask

  task automatic test_flush_rvalid;
    int n; bit to; exp_t e;
    mem_lat = 1;
    consume(1'b0, 32'h0);
    @(posedge clk);
    #1;
    flush_i    = 1'b1;
    flush_pc_i = 32'h40;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin errors++; $display("FAIL fr_req: got req=%b addr=%h want 1 00000040", imem_req_o, imem_addr_o); end
    checks++; if (instr_valid_o !== 1'b0 || instr_o !== mem_word(32'h80)) begin errors++; $display("FAIL fr_dropped: got v=%b instr=%h want 0 %h", instr_valid_o, instr_o, mem_word(32'h80)); end
    sb.push_back('{32'h40, mem_word(32'h40)});
    wait_valid(10, n, to);
    checks++; if (to || n !== 2) begin errors++; $display("FAIL fr_latency: got %0d (timeout=%0d) want 2", n, to); end
    e = sb.pop_front();
    checks++; if (instr_o !== e.instr || PC_o !== e.pc) begin errors++; $display("FAIL fr_data: got %h %h want %h %h", instr_o, PC_o, e.instr, e.pc); end
  endtask

  task automatic test_wrap;
    int n; bit to; exp_t e;
    flush_i    = 1'b1;
    flush_pc_i = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC || instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL wrap_req: got req=%b addr=%h v=%b want 1 fffffffc 0", imem_req_o, imem_addr_o, instr_valid_o);
    end
    sb.push_back('{32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
    wait_valid(10, n, to);
    e = sb.pop_front();
    checks++; if (to || instr_o !== e.instr || PC_o !== e.pc) begin errors++; $display("FAIL wrap_data: got %h %h want %h %h", instr_o, PC_o, e.instr, e.pc); end
    checks++; if (PCPlus4_o !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want 00000000", PCPlus4_o); end
    consume(1'b0, 32'h0);
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_next: got req=%b addr=%h want 1 00000000", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_reset_drain;
    int n; bit to; exp_t e;
    mem_lat    = 3;
    flush_i    = 1'b1;
    flush_pc_i = 32'h200;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || PC_o !== 32'h200) begin
      errors++; $display("FAIL rd_drain: got req=%b v=%b pc=%h want 0 0 00000200", imem_req_o, instr_valid_o, PC_o);
    end
    rst_i = 1'b1;
    #1;
    checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL rd_async_ctl: got req=%b v=%b want 0 0", imem_req_o, instr_valid_o); end
    checks++; if (instr_o !== NOP || PC_o !== RST_PC || imem_addr_o !== RST_PC) begin
      errors++; $display("FAIL rd_async_data: got instr=%h pc=%h addr=%h want %h %h %h", instr_o, PC_o, imem_addr_o, NOP, RST_PC, RST_PC);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_i   = 1'b0;
    mem_lat = 1;
    sb.push_back('{RST_PC, 32'h0050_0093});
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC) begin errors++; $display("FAIL rd_req: got req=%b addr=%h want 1 %h", imem_req_o, imem_addr_o, RST_PC); end
    wait_valid(10, n, to);
    checks++; if (to || n !== 2) begin errors++; $display("FAIL rd_latency: got %0d (timeout=%0d) want 2", n, to); end
    e = sb.pop_front();
    checks++; if (instr_o !== e.instr || PC_o !== e.pc) begin errors++; $display("FAIL rd_data: got %h %h want %h %h", instr_o, PC_o, e.instr, e.pc); end
  endtask

  task automatic test_one_outstanding;
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL one_outstanding: got %0d overlapping requests want 0", overlap_cnt); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size()); end
  endtask

  initial begin
    rst_i      = 1'b1;
    PCSrc_i    = 1'b0;
    PCTarget_i = '0;
    stall_i    = 1'b1;
    flush_i    = 1'b0;
    flush_pc_i = '0;
    test_reset;
    test_stall;
    test_branch;
    test_flush_wait;
    test_flush_rvalid;
    test_wrap;
    test_reset_drain;
    test_one_outstanding;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction-fetch stage of the RV32I core; sits directly upstream of the control unit.
- Holds the program counter and talks to instruction memory over a single-outstanding request/response interface.
- Presents one instruction at a time with a valid flag, together with its PC and PC+4.
- Advances when the instruction is consumed, using the control unit's `PCSrc` to choose between sequential and branch targets; a higher-priority flush redirects fetch from any state and drops in-flight responses.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32: PC and memory address width.
- `INSTR_WIDTH`, default 32: instruction width.
- `RESET_PC`, default 0: PC loaded on reset; bits [1:0] must be 0.

Ports:
- `clk_i` input, 1: clock; all state updates on the rising edge.
- `rst_i` input, 1: asynchronous, active-high reset.
- `PCSrc_i` input, 1: from control unit. 1 = take `PCTarget_i`, 0 = take PC+4. Sampled only on consume.
- `PCTarget_i` input, ADDR_WIDTH: branch/jump target for the current instruction.
- `stall_i` input, 1: downstream not ready; blocks consume.
- `flush_i` input, 1: redirect request (trap or external); highest priority.
- `flush_pc_i` input, ADDR_WIDTH: redirect address.
- `imem_req_o` output, 1: one-cycle fetch request strobe.
- `imem_addr_o` output, ADDR_WIDTH: fetch address; equals the PC register.
- `imem_rvalid_i` input, 1: response valid, at least 1 cycle after the request.
- `imem_rdata_i` input, INSTR_WIDTH: response data.
- `instr_o` output, INSTR_WIDTH: current instruction to the control unit and decode.
- `instr_valid_o` output, 1: `instr_o` is valid.
- `PC_o` output, ADDR_WIDTH: PC of `instr_o`.
- `PCPlus4_o` output, ADDR_WIDTH: `PC_o + 4`, mod 2^ADDR_WIDTH.

## Operation

- States: REQ, WAIT, DRAIN, VALID. State is registered.
  - `imem_req_o` = (state == REQ).
  - `instr_valid_o` = (state == VALID).
- Reset (asynchronous) sets:
  - state = REQ, PC = `RESET_PC`;
  - `instr_o` = 0x00000013 (NOP);
  - `instr_valid_o` = 0.
  - While `rst_i` is high, `imem_req_o` is forced to 0.
- **REQ**: issue the request at PC. Always go to WAIT; memory has no grant signal.
- **WAIT**:
  - On `imem_rvalid_i`: `instr_o` ← `imem_rdata_i`, go to VALID.
  - Otherwise stay in WAIT.
- **VALID**:
  - Consume occurs when `stall_i` = 0.
  - On consume, PC ← (`PCSrc_i` ? `PCTarget_i` : PC+4), with bits [1:0] forced to 0, then go to REQ.
  - When `stall_i` = 1, hold `instr_o`, PC and state.
- **DRAIN**: one response is still owed by memory.
  - On `imem_rvalid_i`: discard the data (`instr_o` unchanged), go to REQ.
- **Flush** (`flush_i` = 1) overrides all of the above in any state.
  - PC ← `flush_pc_i` with bits [1:0] forced to 0. `PCSrc_i` and `stall_i` are ignored that cycle.
  - Next state depends on the current state:
    - REQ → DRAIN, since this cycle's request is outstanding.
    - WAIT with `imem_rvalid_i` = 0 → DRAIN.
    - WAIT with `imem_rvalid_i` = 1 → REQ; the response is dropped and `instr_o` is not updated.
    - DRAIN with `imem_rvalid_i` = 0 → DRAIN.
    - DRAIN with `imem_rvalid_i` = 1 → REQ.
    - VALID → REQ.
- `imem_rvalid_i` in REQ or VALID is a protocol error and is ignored.
- `PC_o` is driven from the PC register.
  - In VALID it is the PC of `instr_o`.
  - In other states it is the PC being fetched.
- PC arithmetic wraps: 0xFFFFFFFC + 4 = 0x00000000.

## Timing

- Cycle 0 after reset deasserts: REQ, with `imem_req_o` = 1 and `imem_addr_o` = `RESET_PC`.
- With memory latency L ≥ 1, `instr_valid_o` rises L+1 cycles after the request cycle.
- With no stall and L = 1, throughput is 1 instruction per 3 cycles (REQ, WAIT, VALID).
- The consume edge updates PC. The new request appears in the next cycle with the new address.
- The flush edge updates PC.
  - If no response is owed, the new request is issued the cycle after the flush.
  - Otherwise it is issued the cycle after the owed `imem_rvalid_i`.
- `instr_valid_o` falls on the edge after a consume or flush.
- At most one memory request is outstanding at any time.

## Test plan

- **Reset fetch**: `RESET_PC` = 0x100, memory latency 1, rdata 0x00500093.
  - Request at 0x100 on cycle 0.
  - `instr_valid_o` = 1 on cycle 2 with `instr_o` = 0x00500093, `PC_o` = 0x100, `PCPlus4_o` = 0x104.
- **Sequential with stall**: hold `stall_i` = 1 for 4 cycles in VALID.
  - `instr_o`, `PC_o` and `instr_valid_o` stay stable.
  - After `stall_i` drops, the next request goes to 0x104.
- **Branch taken**: in VALID, drive `PCSrc_i` = 1 and `PCTarget_i` = 0x2002 with `stall_i` = 0.
  - Next request address is 0x2000.
  - With `PCSrc_i` = 0 instead, the next request address is PC+4.
- **Flush during WAIT**: memory latency 3; assert `flush_i` with `flush_pc_i` = 0x80 one cycle after the request.
  - The stale response is dropped and `instr_valid_o` stays 0.
  - The next request goes to 0x80 the cycle after the stale `imem_rvalid_i`.
- **Simultaneous flush and rvalid** in WAIT (`flush_pc_i` = 0x40):
  - `instr_o` is unchanged and no VALID cycle occurs.
  - A request at 0x40 is issued the next cycle.
- **Wrap and mid-operation reset**:
  - Consume at PC 0xFFFFFFFC with `PCSrc_i` = 0: the next request goes to 0x0.
  - Assert `rst_i` in DRAIN: outputs return to reset values immediately, and after release the request goes to `RESET_PC`.
